reg_stream_loader: RTL and testbench
====================================

REG_STREAM_LOADER -- requirements
Module: reg_stream_loader

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 16: register word width in bits; must be a multiple of 8.
REQ-002 The block SHALL have parameter REGBITS, default 4: register address width; registers loaded = 2**REGBITS.
Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to begin a load pass.
REQ-006 The block SHALL have port in_data, input, 8 bits: stream byte.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-009 The block SHALL have port regWrite, output, 1 bit: register-file write enable.
REQ-010 The block SHALL have port destAddr, output, REGBITS bits: register-file write address.
REQ-011 The block SHALL have port wrData, output, WIDTH bits: register-file write data.
REQ-012 The block SHALL have port busy, output, 1 bit: a load pass is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when a pass completes.

Function
REQ-014 The block SHALL implement FSM states IDLE, COLLECT, WRITE and DONE.
REQ-015 In IDLE, start=1 SHALL move the FSM to COLLECT and clear the address counter and byte counter to 0; start in any other state SHALL be ignored.
REQ-016 in_ready SHALL be 1 only in COLLECT, and a byte SHALL transfer exactly on cycles where in_valid=1 and in_ready=1.
REQ-017 Bytes SHALL assemble most-significant byte first; after WIDTH/8 transfers the FSM SHALL enter WRITE on the next cycle.
REQ-018 In WRITE, regWrite SHALL be 1 for exactly one cycle with destAddr = address counter and wrData = the assembled word; regWrite SHALL be 0 in every other state.
REQ-019 After a WRITE with address counter less than 2**REGBITS-1, the address counter SHALL increment, the byte counter SHALL clear, and the FSM SHALL return to COLLECT.
REQ-020 After a WRITE at address 2**REGBITS-1, the FSM SHALL enter DONE; DONE SHALL assert done=1 for one cycle and then return to IDLE.
REQ-021 The address counter SHALL NOT wrap within a pass.
REQ-022 Register 0 SHALL be written like any other address.
REQ-023 in_valid stalls (in_valid=0) SHALL hold all state with no timeout.
REQ-024 busy SHALL be 1 in COLLECT and WRITE, and 0 in IDLE and DONE.
REQ-025 destAddr and wrData SHALL hold their last written values outside WRITE.
REQ-026 Minimum pass latency from start to done SHALL be 2**REGBITS*(WIDTH/8+1)+2 cycles.

Reset
REQ-027 reset=1 SHALL asynchronously force the FSM to IDLE, both counters and the assembly register to 0, and in_ready, regWrite, destAddr, wrData, busy and done to 0.
REQ-028 Reset mid-pass SHALL discard any partial word, issue no regWrite, and leave already-written registers to the register file.
REQ-029 After reset deasserts, the block SHALL do nothing until a new start.

Structure
REQ-030 The FSM state encoding and the BYTES_PER_WORD = WIDTH/8 constant SHALL live in a shared package.
REQ-031 Byte assembly SHALL be one sub-module, word_assembler: a WIDTH-bit shift register with load, clear and byte-count outputs.

Verification
REQ-032 The bench SHALL cover full pass, no stalls: start, then 32 bytes 0x00,0x00,0x11,0x11,...,0xFF,0xFF -> 16 regWrite pulses writing r(n) = 0xnnnn, done after 50 cycles.
REQ-033 The bench SHALL cover stalls: in_valid toggled randomly -> same 16 writes in order, busy held throughout, no extra regWrite.
REQ-034 The bench SHALL cover start during busy: a second start pulse mid-pass -> ignored, counters unchanged, single done.
REQ-035 The bench SHALL cover mid-pass reset: reset after the 7th byte -> all outputs 0 immediately, no regWrite; a new pass then writes r0 from the first two new bytes.
REQ-036 The bench SHALL cover byte order: bytes 0xAB,0xCD -> wrData=0xABCD, destAddr=0.
REQ-037 The bench SHALL cover in_valid with no pass running: in_valid=1 in IDLE -> in_ready=0, no byte consumed.

Source files
------------

// File: rtl/reg_stream_loader_pkg.sv
// Shared definitions for the register stream loader: FSM encoding and word sizing.
package reg_stream_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loaderState_t;

    localparam int unsigned DEFAULT_WIDTH  = 16;
    localparam int unsigned BYTES_PER_WORD = DEFAULT_WIDTH / 8;

    // Number of stream bytes that make up one register word.
    function automatic int unsigned bytesPerWord(input int unsigned width);
        return width / 8;
    endfunction

    // Width of a counter that can hold 0..bytesPerWord(width).
    function automatic int unsigned countBits(input int unsigned width);
        return $clog2(width / 8) + 1;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Shift register that builds a WIDTH-bit word from bytes, most-significant byte first.
module word_assembler
    import reg_stream_loader_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNTW  = countBits(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [7:0]       byteIn,
    output logic [WIDTH-1:0] wordNext_c,
    output logic [CNTW-1:0]  byteCount
);

    logic [WIDTH-1:0] word;

    // Word as it will look once the current byte is shifted in.
    assign wordNext_c = (word << 8) | WIDTH'(byteIn);

    // Shift register and byte counter; clear wins over load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word      <= '0;
            byteCount <= '0;
        end else if (clear) begin
            word      <= '0;
            byteCount <= '0;
        end else if (load) begin
            word      <= wordNext_c;
            byteCount <= byteCount + CNTW'(1);
        end
    end

endmodule

// File: rtl/reg_stream_loader.sv
// Loads every register of a register file from a byte stream, one word per address.
module reg_stream_loader
    import reg_stream_loader_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               regWrite,
    output logic [REGBITS-1:0] destAddr,
    output logic [WIDTH-1:0]   wrData,
    output logic               busy,
    output logic               done
);

    localparam int unsigned       BYTES     = bytesPerWord(WIDTH);
    localparam int unsigned       CNTW      = countBits(WIDTH);
    localparam logic [REGBITS-1:0] LAST_ADDR = {REGBITS{1'b1}};
    localparam logic [CNTW-1:0]    LAST_BYTE = CNTW'(BYTES - 1);

    loaderState_t       state;
    loaderState_t       stateNext;
    logic [REGBITS-1:0] addrCnt;
    logic [CNTW-1:0]    byteCount;
    logic [WIDTH-1:0]   wordNext;
    logic               byteFire;
    logic               lastByte;
    logic               lastAddr;
    logic               asmClear;
    logic               addrClear;
    logic               addrInc;
    logic               inReadyNext;
    logic               regWriteNext;
    logic               busyNext;
    logic               doneNext;

    // in_ready is high exactly while in COLLECT, so it qualifies the transfer.
    assign byteFire = in_valid && in_ready;
    assign lastByte = (byteCount == LAST_BYTE);
    assign lastAddr = (addrCnt == LAST_ADDR);

    word_assembler #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (asmClear),
        .load       (byteFire),
        .byteIn     (in_data),
        .wordNext_c (wordNext),
        .byteCount  (byteCount)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = COLLECT;
            COLLECT: if (byteFire && lastByte) stateNext = WRITE;
            WRITE:   stateNext = lastAddr ? DONE : COLLECT;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output decode: outputs are computed from the next state so the registered
    // versions line up with the state they describe.
    always_comb begin
        asmClear     = 1'b0;
        addrClear    = 1'b0;
        addrInc      = 1'b0;
        inReadyNext  = (stateNext == COLLECT);
        regWriteNext = (stateNext == WRITE);
        busyNext     = (stateNext == COLLECT) || (stateNext == WRITE);
        doneNext     = (stateNext == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    asmClear  = 1'b1;
                    addrClear = 1'b1;
                end
            end
            WRITE: begin
                asmClear = 1'b1;
                addrInc  = !lastAddr;
            end
            default: ;
        endcase
    end

    // Output registers; write address/data only change when a write is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready <= 1'b0;
            regWrite <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            destAddr <= '0;
            wrData   <= '0;
        end else begin
            in_ready <= inReadyNext;
            regWrite <= regWriteNext;
            busy     <= busyNext;
            done     <= doneNext;
            if (regWriteNext) begin
                destAddr <= addrCnt;
                wrData   <= wordNext;
            end
        end
    end

    // Register address counter; never wraps because DONE follows the last address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addrCnt <= '0;
        end else if (addrClear) begin
            addrCnt <= '0;
        end else if (addrInc) begin
            addrCnt <= addrCnt + REGBITS'(1);
        end
    end

endmodule

// File: tb/tb_reg_stream_loader.sv
// Scoreboard bench for reg_stream_loader: random byte streams vs. a word-list model.
module tb_reg_stream_loader;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned REGBITS = 4;
    localparam int unsigned NREGS   = 1 << REGBITS;
    localparam int unsigned BPW     = WIDTH / 8;
    localparam int unsigned NBYTES  = NREGS * BPW;
    localparam int          PASS_LATENCY = NREGS * (BPW + 1) + 2;

    typedef struct packed {
        logic [REGBITS-1:0] addr;
        logic [WIDTH-1:0]   data;
    } wrExp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               regWrite;
    logic [REGBITS-1:0] destAddr;
    logic [WIDTH-1:0]   wrData;
    logic               busy;
    logic               done;

    wrExp_t     expQ[$];
    logic [7:0] txBytes[NBYTES];
    int         errors    = 0;
    int         checks    = 0;
    int         cyc       = 0;
    int         doneCount = 0;

    reg_stream_loader #(
        .WIDTH   (WIDTH),
        .REGBITS (REGBITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .regWrite (regWrite),
        .destAddr (destAddr),
        .wrData   (wrData),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutputsZero(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_regWrite"}, 32'(regWrite), 32'd0);
        check({tag, "_destAddr"}, 32'(destAddr), 32'd0);
        check({tag, "_wrData"},   32'(wrData),   32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
    endtask

    // Monitor: every regWrite must match the oldest expected write.
    always @(negedge clk) begin
        wrExp_t e;
        if (done) doneCount++;
        if (regWrite) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=0x%0h, none expected", destAddr, wrData);
            end else begin
                e = expQ.pop_front();
                check("write_addr", 32'(destAddr), 32'(e.addr));
                check("write_data", 32'(wrData), 32'(e.data));
            end
        end
    end

    task automatic driveByte(input int idx, input int stallPct);
        if (idx < NBYTES && (stallPct == 0 || $urandom_range(99) >= stallPct)) begin
            in_valid = 1'b1;
            in_data  = txBytes[idx];
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < NBYTES; i++) txBytes[i] = 8'($urandom);
    endtask

    // One load pass. restartAt: loop iteration with a stray start pulse (0 = none).
    // resetAfter: assert reset once this many bytes have transferred (0 = none).
    task automatic runPass(input int stallPct, input int restartAt, input int resetAfter);
        int     idx;
        int     iter;
        int     startCyc;
        int     doneBefore;
        bit     fire;
        bit     finished;
        wrExp_t e;
        idx      = 0;
        iter     = 0;
        finished = 1'b0;
        for (int w = 0; w < NREGS; w++) begin
            if (resetAfter == 0 || (w + 1) * BPW <= resetAfter) begin
                e.addr = REGBITS'(w);
                e.data = {txBytes[2*w], txBytes[2*w+1]};
                expQ.push_back(e);
            end
        end
        doneBefore = doneCount;

        @(posedge clk);
        #1;
        start = 1'b1;
        driveByte(idx, stallPct);
        @(negedge clk);
        startCyc = cyc;
        fire = in_valid && in_ready;
        @(posedge clk);
        if (fire) idx++;
        #1;
        start = 1'b0;

        while (!finished) begin
            iter++;
            if (iter > 4000) begin
                checks++;
                errors++;
                $display("FAIL pass_timeout: no done after %0d cycles, %0d bytes sent", iter, idx);
                break;
            end
            driveByte(idx, stallPct);
            start = (iter == restartAt);
            @(negedge clk);
            fire = in_valid && in_ready;
            if (done) begin
                check("busy_in_done", 32'(busy), 32'd0);
                check("bytes_at_done", 32'(idx), 32'(NBYTES));
                if (stallPct == 0) check("pass_latency", 32'(cyc - startCyc + 1), 32'(PASS_LATENCY));
                finished = 1'b1;
            end else begin
                check("busy_in_pass", 32'(busy), 32'd1);
            end
            @(posedge clk);
            if (fire) idx++;
            if (resetAfter != 0 && idx == resetAfter) begin
                #1;
                reset    = 1'b1;
                start    = 1'b0;
                in_valid = 1'b0;
                #1;
                checkOutputsZero("reset_mid");
                check("writes_before_reset", 32'(expQ.size()), 32'd0);
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b0;
                in_valid = 1'b1;
                in_data  = 8'h3C;
                repeat (3) begin
                    @(negedge clk);
                    check("post_reset_in_ready", 32'(in_ready), 32'd0);
                    check("post_reset_busy", 32'(busy), 32'd0);
                end
                in_valid = 1'b0;
                return;
            end
            #1;
        end

        in_valid = 1'b0;
        start    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("done_pulses", 32'(doneCount - doneBefore), 32'd1);
        check("writes_left", 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutputsZero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Valid data with no pass running must not be consumed.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (4) begin
            @(negedge clk);
            check("idle_in_ready", 32'(in_ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
        in_valid = 1'b0;

        // Byte order: first word 0xAB,0xCD lands at register 0 as 0xABCD.
        fillRandom();
        txBytes[0] = 8'hAB;
        txBytes[1] = 8'hCD;
        runPass(0, 0, 0);
        check("hold_destAddr", 32'(destAddr), 32'(NREGS - 1));
        check("hold_wrData", 32'(wrData), 32'({txBytes[NBYTES-2], txBytes[NBYTES-1]}));

        // Full pass, no stalls: r(n) = 0xnnnn.
        for (int n = 0; n < NREGS; n++) begin
            txBytes[2*n]   = 8'(n * 8'h11);
            txBytes[2*n+1] = 8'(n * 8'h11);
        end
        runPass(0, 0, 0);

        // Random in_valid stalls.
        fillRandom();
        runPass(40, 0, 0);

        // Stray start while busy.
        fillRandom();
        runPass(25, 13, 0);

        // Reset after the 7th byte, then a clean pass.
        fillRandom();
        runPass(30, 0, 7);
        fillRandom();
        runPass(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
